// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter and select sequencer for the shared 8:1 bit mux.
// Eight level-sensitive requesters contend for the mux output. One owner
// is granted at a time. The block drives the mux select directly, along
// with a one-hot grant vector and a valid flag. All outputs are registered.
//
// Optional feature:
//   Define MUX8_ARB_HOLD_LIMIT_EN to compile in the hold limit. When it is
//   defined, an owner that has held the mux for MAX_HOLD consecutive cycles
//   is re-arbitrated even though it is still requesting. When it is not
//   defined, an owner keeps the grant until it drops its request.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (1..255).
//             Used only when the hold limit is compiled in.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   req    in   [7:0] request vector, bit i = requester i
//   sel    out  [2:0] mux select (index of the current owner)
//   grant  out  [7:0] one-hot grant, zero when idle
//   valid  out  high while a grant is active
//   chg    out  one-cycle pulse on the first cycle of a grant to a new owner
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       valid,
    output logic       chg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_reg, state_next;
    logic [2:0] sel_reg,   sel_next;
    logic [2:0] ptr_reg,   ptr_next;
    logic [7:0] grant_reg, grant_next;
    logic [7:0] cnt_reg,   cnt_next;
    logic       chg_reg,   chg_next;

    logic [7:0] rot_req;
    logic [2:0] rot_off;
    logic [2:0] arb_idx;
    logic       any_req;
    logic       hold_hit;
    logic       do_load;

    // Rotate the request vector so that bit 0 corresponds to the requester
    // at ptr_reg. The 3-bit sum wraps naturally, giving the mod-8 search.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[3'(ptr_reg + 3'(gi))];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the winner's offset from ptr.
    always_comb begin
        rot_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_off = 3'(i);
            end
        end
    end

    assign any_req = |req;
    assign arb_idx = 3'(ptr_reg + rot_off);

`ifdef MUX8_ARB_HOLD_LIMIT_EN
    // The hold limit re-arbitrates from sel+1. Every grant load already
    // set ptr to owner+1, so the shared rotator gives the right search
    // start without a separate path.
    assign hold_hit = (cnt_reg == HOLD_LAST);
`else
    logic unused_hold;
    assign hold_hit    = 1'b0;
    assign unused_hold = (cnt_reg == HOLD_LAST);
`endif

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        cnt_next   = cnt_reg;
        chg_next   = 1'b0;
        do_load    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    do_load = 1'b1;
                end
            end
            GRANT: begin
                if (!req[sel_reg] || hold_hit) begin
                    if (any_req) begin
                        // Handover in the same cycle: no idle gap.
                        do_load = 1'b1;
                    end else begin
                        // sel and ptr keep their values while idle.
                        state_next = IDLE;
                        grant_next = 8'h00;
                    end
                end else if (cnt_reg != 8'hFF) begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 8'h00;
            end
        endcase

        if (do_load) begin
            state_next = GRANT;
            sel_next   = arb_idx;
            grant_next = 8'h01 << arb_idx;
            cnt_next   = 8'h00;
            ptr_next   = 3'(arb_idx + 3'd1);
            // A sole requester re-granted by the hold limit is not a change.
            chg_next   = (state_reg == IDLE) || (arb_idx != sel_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 3'd0;
            ptr_reg   <= 3'd0;
            grant_reg <= 8'h00;
            cnt_reg   <= 8'h00;
            chg_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            cnt_reg   <= cnt_next;
            chg_reg   <= chg_next;
        end
    end

    assign sel   = sel_reg;
    assign grant = grant_reg;
    assign valid = (state_reg == GRANT);
    assign chg   = chg_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_arbiter
//
// Self-checking bench for mux8_rr_arbiter. Each stimulus cycle updates a
// behavioural reference model and pushes the expected outputs to a
// scoreboard queue. The entry is popped and compared after the clock edge.
// Directed checks from the test plan are mixed in, followed by a
// randomised run with occasional resets.
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef MUX8_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       chg;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .sel   (sel),
        .grant (grant),
        .valid (valid),
        .chg   (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] grant;
        logic       valid;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [2:0] m_sel   = 3'd0;
    logic [2:0] m_ptr   = 3'd0;
    logic       m_valid = 1'b0;
    logic       m_chg   = 1'b0;
    int         m_cnt   = 0;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp_v, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] q);
        exp_t       e;
        logic       rearb;
        logic       found;
        logic [2:0] start;
        logic [2:0] idx;
        if (r) begin
            m_sel   = 3'd0;
            m_ptr   = 3'd0;
            m_valid = 1'b0;
            m_chg   = 1'b0;
            m_cnt   = 0;
        end else begin
            m_chg = 1'b0;
            rearb = !m_valid || !q[m_sel] || (HOLD_EN && m_cnt == MAX_HOLD - 1);
            if (!rearb) begin
                if (m_cnt < 255) m_cnt++;
            end else begin
                start = (m_valid && q[m_sel]) ? 3'(m_sel + 3'd1) : m_ptr;
                found = 1'b0;
                idx   = 3'd0;
                for (int k = 0; k < 8; k++) begin
                    if (!found && q[(int'(start) + k) % 8]) begin
                        found = 1'b1;
                        idx   = 3'((int'(start) + k) % 8);
                    end
                end
                if (found) begin
                    m_chg   = !m_valid || (idx != m_sel);
                    m_sel   = idx;
                    m_valid = 1'b1;
                    m_ptr   = 3'(idx + 3'd1);
                    m_cnt   = 0;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        e.sel   = m_sel;
        e.grant = m_valid ? (8'h01 << m_sel) : 8'h00;
        e.valid = m_valid;
        e.chg   = m_chg;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive on the falling edge, compare 1 ns after rising.
    task automatic step(input logic r, input logic [7:0] q);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = q;
        model_step(r, q);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 8'h01, 8'h00);
        end else begin
            e = exp_q.pop_front();
            check_eq("sb_sel",   {5'd0, sel},   {5'd0, e.sel});
            check_eq("sb_grant", grant,         e.grant);
            check_eq("sb_valid", {7'd0, valid}, {7'd0, e.valid});
            check_eq("sb_chg",   {7'd0, chg},   {7'd0, e.chg});
            check_eq("inv_gsel", {7'd0, grant[sel]}, {7'd0, valid});
            check_eq("inv_1hot", {7'd0, $onehot0(grant)}, 8'h01);
        end
        $display("cyc t=%0t rst=%0b req=%02h -> sel=%0d grant=%02h valid=%0b chg=%0b",
                 $time, r, q, sel, grant, valid, chg);
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;

        // Reset with all requests asserted.
        step(1'b1, 8'hFF);
        step(1'b1, 8'hFF);
        check_eq("tp_rst_grant", grant, 8'h00);
        check_eq("tp_rst_sel",   {5'd0, sel}, 8'h00);
        check_eq("tp_rst_valid", {7'd0, valid}, 8'h00);
        step(1'b0, 8'hFF);
        check_eq("tp_first_grant", grant, 8'h01);
        check_eq("tp_first_chg",   {7'd0, chg}, 8'h01);

        // Handover 2 -> 5 with no gap, then wrap to 0, then idle.
        step(1'b0, 8'h00);
        step(1'b0, 8'h24);
        check_eq("tp_ho_grant2", grant, 8'h04);
        check_eq("tp_ho_sel2",   {5'd0, sel}, 8'h02);
        step(1'b0, 8'h24);
        step(1'b0, 8'h20);
        check_eq("tp_ho_grant5", grant, 8'h20);
        check_eq("tp_ho_sel5",   {5'd0, sel}, 8'h05);
        check_eq("tp_ho_chg",    {7'd0, chg}, 8'h01);
        check_eq("tp_ho_valid",  {7'd0, valid}, 8'h01);
        step(1'b0, 8'h03);
        check_eq("tp_wrap_grant", grant, 8'h01);
        step(1'b0, 8'h00);
        check_eq("tp_idle_grant", grant, 8'h00);
        check_eq("tp_idle_sel",   {5'd0, sel}, 8'h00);

        // Hold limit, starting from a fresh reset so ptr=0.
        step(1'b1, 8'h00);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'h09);
            if (i == 0) check_eq("tp_hold_c0", grant, 8'h01);
            if (i == 4) check_eq("tp_hold_c4", grant, HOLD_EN ? 8'h08 : 8'h01);
            if (i == 8) check_eq("tp_hold_c8", grant, 8'h01);
        end
        step(1'b0, 8'h00);

        // Sole requester for 12 cycles.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'h10);
            check_eq("tp_sole_grant", grant, 8'h10);
            check_eq("tp_sole_chg",   {7'd0, chg}, (i == 0) ? 8'h01 : 8'h00);
        end
        step(1'b0, 8'h00);

        // Reset in the middle of a grant.
        step(1'b0, 8'hC0);
        check_eq("tp_mid_before", grant, 8'h40);
        step(1'b1, 8'hC0);
        check_eq("tp_mid_rst", grant, 8'h00);
        step(1'b0, 8'hC0);
        check_eq("tp_mid_after", grant, 8'h40);

        // Randomised traffic with sparse resets.
        begin
            logic [7:0] rq;
            rq = 8'h00;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
                if ($urandom_range(0, 9) == 0) rq = 8'h00;
                step(($urandom_range(0, 63) == 0), rq);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and select sequencer for the shared 8:1 bit multiplexer. Eight requesters contend for the single output of the mux. This block grants one requester at a time and drives the mux `sel[2:0]` directly, together with a one-hot grant vector and a valid flag. It sits immediately upstream of the mux select input, in the same clock domain as the requesters.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per owner when the hold limit is compiled in. Legal range 1..255.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 8: request vector; bit i is requester i, level-sensitive.
- `sel` output 3: mux select, the index of the current owner.
- `grant` output 8: one-hot grant; all zero when idle.
- `valid` output 1: high while a grant is active, i.e. `sel` is meaningful.
- `chg` output 1: one-cycle pulse on the first cycle of a grant to a different owner index.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner = `sel`.
- Internal registers:
  - `ptr[2:0]`: priority start index.
  - `cnt[7:0]`: hold counter.
- Arbitration function: first set bit of `req` searching `ptr`, `ptr+1`, ..., `ptr+7`, mod 8.
- IDLE:
  - `req==0`: stay in IDLE.
  - Otherwise: enter GRANT with the arbitrated index.
  - Grant load: `sel`=index, `grant`=1<<index, `valid`=1, `cnt`=0, `ptr`=index+1 mod 8 (3-bit wrap, 7+1=0).
- GRANT, owner still requesting and no hold limit reached: keep owner, `cnt`++ (saturating at 255).
- GRANT, `req[sel]==0`: re-arbitrate in the same cycle.
  - Some request present: grant load, with no idle gap.
  - `req==0`: go to IDLE, `grant`=0, `valid`=0.
  - `sel` keeps its last value in IDLE; `ptr` is unchanged.
- `chg`=1 for one cycle whenever a grant load selects an index different from the previous owner, and on every IDLE->GRANT load. `chg`=0 otherwise.
- `grant` is always one-hot or zero. `grant[sel]==valid` at all times.

## Timing
- All outputs are registered.
- Request-to-grant latency: `req` sampled at edge k, so `grant`/`sel`/`valid` change after edge k.
- Release: owner drops `req` before edge m, so the new owner (or idle) is visible after edge m. There is no dead cycle between owners.
- Reset: `rst` sampled high at an edge forces, after that edge:
  - `sel`=0, `grant`=0, `valid`=0, `chg`=0.
  - `ptr`=0, `cnt`=0, state IDLE.
- Reset mid-grant: the grant drops at that edge.
- First arbitration after reset starts from index 0.
- Simultaneous owner release and new requests: resolved by `ptr`, which is the former owner+1, so the former owner has lowest priority.
- Requests arriving during a grant wait; they never pre-empt except via the hold limit.

## Configuration
- Macro `MUX8_ARB_HOLD_LIMIT_EN`.
- Defined:
  - In GRANT, if `req[sel]==1` and `cnt==MAX_HOLD-1`, re-arbitrate with `ptr`=`sel`+1. This is a grant load with `cnt`=0.
  - If the owner is the sole requester, it is re-granted: `valid` stays high and `chg`=0.
  - With `MAX_HOLD`=1, ownership rotates every cycle among active requesters.
- Undefined:
  - `MAX_HOLD` is ignored and `cnt` is unused.
  - The owner holds until it deasserts `req`.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=8'hFF.
  - During reset: `grant`=0, `sel`=0, `valid`=0.
  - First edge after release: `grant`=8'h01, `sel`=0, `valid`=1, `chg`=1.
- Handover: `req`=8'h24 from idle, so `grant`=8'h04 and `sel`=2. Then clear bit 2, so the next edge gives `grant`=8'h20, `sel`=5, `chg`=1, and `valid` stays high continuously.
- Wrap: after owner 5 releases with `req`=8'h03, `grant`=8'h01 and `sel`=0, showing `ptr` wrap 6->7->0. Dropping all requests gives `valid`=0, `grant`=0, `sel`=0.
- Hold limit with macro defined, `MAX_HOLD`=4, `req`=8'h09 constant: `grant` alternates 8'h01 for 4 cycles, then 8'h08 for 4 cycles, with a `chg` pulse at each switch. Without the macro: `grant`=8'h01 indefinitely.
- Sole requester, macro defined, `MAX_HOLD`=4, `req`=8'h10 for 12 cycles: `grant`=8'h10 and `valid`=1 throughout. `chg` pulses only on the first cycle.
- Reset mid-grant: `rst` pulsed while `grant`=8'h40, `req`=8'hC0. After the reset edge, `grant`=0. After release, `grant`=8'h40 because `ptr` was reset to 0 and bit 6 is the first set bit.
